// File: rtl/rgmii_mac_tx.sv
// RGMII MAC transmitter: wraps an 8-bit AXI-stream frame in preamble/SFD, pads it, appends the FCS
// and enforces the inter-frame gap, presenting both DDR nibbles as registered outputs for an ODDR.
module rgmii_mac_tx #(
   parameter int IFG_BYTES        = 12,
   parameter int MIN_FRAME_LENGTH = 64,
   parameter bit ENABLE_PADDING   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [3:0] rgmii_txd_1,
   output logic [3:0] rgmii_txd_2,
   output logic       rgmii_tx_ctl_1,
   output logic       rgmii_tx_ctl_2,
   output logic       start_packet,
   output logic       error_underflow
);

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, PAD, FCS, IFG} state_t;

   localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_LENGTH - 4);
   localparam logic [7:0]  IFG_LAST   = 8'(IFG_BYTES - 1);

   state_t      state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic [15:0] len, len_next, len_inc;
   logic [31:0] crc, crc_next, fcs;
   logic [7:0]  tx_byte_p0;
   logic        tx_en_p0, tx_er_p0, sop_p0, underrun_p0;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign s_axis_tready = (state == PAYLOAD) || (state == DRAIN);
   assign fcs           = ~crc;
   assign len_inc       = sat_inc(len);

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      len_next    = len;
      crc_next    = crc;
      tx_byte_p0  = 8'h00;
      tx_en_p0    = 1'b0;
      tx_er_p0    = 1'b0;
      sop_p0      = 1'b0;
      underrun_p0 = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_tvalid) begin
               state_next = PREAMBLE;
               cnt_next   = 8'd0;
            end
         end
         PREAMBLE: begin
            tx_byte_p0 = 8'h55;
            tx_en_p0   = 1'b1;
            sop_p0     = (cnt == 8'd0);
            cnt_next   = cnt + 8'd1;
            if (cnt == 8'd6) state_next = SFD;
         end
         SFD: begin
            tx_byte_p0 = 8'hD5;
            tx_en_p0   = 1'b1;
            crc_next   = 32'hFFFFFFFF;
            len_next   = 16'd0;
            state_next = PAYLOAD;
         end
         PAYLOAD: begin
            tx_en_p0 = 1'b1;
            if (s_axis_tvalid) begin
               tx_byte_p0 = s_axis_tdata;
               crc_next   = crc_byte(crc, s_axis_tdata);
               len_next   = len_inc;
               if (s_axis_tlast) begin
                  cnt_next = 8'd0;
                  if (s_axis_tuser) begin
                     tx_er_p0   = 1'b1;
                     state_next = IFG;
                  end else if (ENABLE_PADDING && (len_inc < PAD_TARGET)) begin
                     state_next = PAD;
                  end else begin
                     state_next = FCS;
                  end
               end
            end else begin
               // Source ran dry mid-frame: poison the frame on the wire and swallow the rest.
               tx_er_p0    = 1'b1;
               underrun_p0 = 1'b1;
               state_next  = DRAIN;
            end
         end
         DRAIN: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_next = IFG;
               cnt_next   = 8'd0;
            end
         end
         PAD: begin
            tx_en_p0 = 1'b1;
            crc_next = crc_byte(crc, 8'h00);
            len_next = len_inc;
            if (len_inc >= PAD_TARGET) begin
               state_next = FCS;
               cnt_next   = 8'd0;
            end
         end
         FCS: begin
            tx_en_p0 = 1'b1;
            case (cnt[1:0])
               2'd0:    tx_byte_p0 = fcs[7:0];
               2'd1:    tx_byte_p0 = fcs[15:8];
               2'd2:    tx_byte_p0 = fcs[23:16];
               default: tx_byte_p0 = fcs[31:24];
            endcase
            cnt_next = cnt + 8'd1;
            if (cnt == 8'd3) begin
               state_next = IFG;
               cnt_next   = 8'd0;
            end
         end
         IFG: begin
            cnt_next = cnt + 8'd1;
            if (cnt == IFG_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stage p0 -> pins: every output is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 8'd0;
         len             <= 16'd0;
         crc             <= 32'hFFFFFFFF;
         rgmii_txd_1     <= 4'd0;
         rgmii_txd_2     <= 4'd0;
         rgmii_tx_ctl_1  <= 1'b0;
         rgmii_tx_ctl_2  <= 1'b0;
         start_packet    <= 1'b0;
         error_underflow <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         len             <= len_next;
         crc             <= crc_next;
         rgmii_txd_1     <= tx_byte_p0[3:0];
         rgmii_txd_2     <= tx_byte_p0[7:4];
         rgmii_tx_ctl_1  <= tx_en_p0;
         rgmii_tx_ctl_2  <= tx_en_p0 ^ tx_er_p0;
         start_packet    <= sop_p0;
         error_underflow <= underrun_p0;
      end
   end

endmodule

// File: tb/tb_rgmii_mac_tx.sv
// Bench for rgmii_mac_tx: a padding and a non-padding instance share one AXI-stream driver; each
// captured wire stream is compared with a frame-level model built from the Ethernet framing rules.
module tb_rgmii_mac_tx;

   typedef logic [7:0]  bq8_t[$];
   typedef logic [11:0] wq_t[$];
   typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;

   localparam int MIN_LEN = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tdata;
   logic       tvalid, tlast, tuser;

   logic       p_tready, n_tready;
   logic [3:0] p_txd1, p_txd2, n_txd1, n_txd2;
   logic       p_ctl1, p_ctl2, n_ctl1, n_ctl2;
   logic       p_sp, p_uf, n_sp, n_uf;

   int checks = 0;
   int errors = 0;

   beat_t bq[$];
   wq_t   e0, e1, w0, w1;
   int    nfr = 0;
   bit    mon_on = 1'b0;

   always #4 clk = ~clk;

   rgmii_mac_tx u_pad (
      .clk(clk), .rst(rst),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(p_tready),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .rgmii_txd_1(p_txd1), .rgmii_txd_2(p_txd2),
      .rgmii_tx_ctl_1(p_ctl1), .rgmii_tx_ctl_2(p_ctl2),
      .start_packet(p_sp), .error_underflow(p_uf)
   );

   rgmii_mac_tx #(.ENABLE_PADDING(1'b0)) u_nopad (
      .clk(clk), .rst(rst),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(n_tready),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .rgmii_txd_1(n_txd1), .rgmii_txd_2(n_txd2),
      .rgmii_tx_ctl_1(n_ctl1), .rgmii_tx_ctl_2(n_ctl2),
      .start_packet(n_sp), .error_underflow(n_uf)
   );

   // Wire entry: {underflow, start_packet, ctl_1, ctl_2, txd_2, txd_1}
   always @(negedge clk) begin
      if (mon_on) begin
         w0.push_back({p_uf, p_sp, p_ctl1, p_ctl2, p_txd2, p_txd1});
         w1.push_back({n_uf, n_sp, n_ctl1, n_ctl2, n_txd2, n_txd1});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ent(input bit uf, input bit sp, input bit en, input bit er,
                                       input logic [7:0] b);
      return {uf, sp, en, en ^ er, b};
   endfunction

   function automatic logic [31:0] crc32(input bq8_t d);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'd0, d[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic wq_t model_frame(input bq8_t p, input bit abort, input int under_at, input bit pad);
      wq_t         e;
      bq8_t        f;
      logic [31:0] fcs;
      for (int i = 0; i < 7; i++) e.push_back(ent(1'b0, i == 0, 1'b1, 1'b0, 8'h55));
      e.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'hD5));
      if (under_at >= 0) begin
         for (int i = 0; i < under_at; i++) e.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, p[i]));
         e.push_back(ent(1'b1, 1'b0, 1'b1, 1'b1, 8'h00));
         return e;
      end
      for (int i = 0; i < p.size(); i++)
         e.push_back(ent(1'b0, 1'b0, 1'b1, abort && (i == p.size() - 1), p[i]));
      if (abort) return e;
      f = p;
      while (pad && (f.size() < MIN_LEN - 4)) begin
         f.push_back(8'h00);
         e.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
      end
      fcs = crc32(f);
      for (int k = 0; k < 4; k++) e.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, fcs[8*k +: 8]));
      return e;
   endfunction

   function automatic bq8_t rand_payload(input int n);
      bq8_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   task automatic add_frame(input bq8_t p, input bit abort, input int under_at);
      wq_t t;
      if (nfr > 0) begin
         repeat (13) begin
            e0.push_back(12'h000);
            e1.push_back(12'h000);
         end
      end
      for (int i = 0; i < p.size(); i++)
         bq.push_back('{d: p[i], l: (i == p.size() - 1), u: abort && (i == p.size() - 1)});
      t = model_frame(p, abort, under_at, 1'b1);
      foreach (t[i]) e0.push_back(t[i]);
      t = model_frame(p, abort, under_at, 1'b0);
      foreach (t[i]) e1.push_back(t[i]);
      nfr++;
   endtask

   task automatic drive(input string tag, input int gap_at);
      int idx = 0;
      int cyc = 0;
      bit hs, gapped;
      gapped = 1'b0;
      while (idx < bq.size() && cyc < 5000) begin
         if (idx == gap_at && !gapped) begin
            tvalid = 1'b0;
            gapped = 1'b1;
         end else begin
            tvalid = 1'b1;
            tdata  = bq[idx].d;
            tlast  = bq[idx].l;
            tuser  = bq[idx].u;
         end
         @(negedge clk);
         hs = tvalid && p_tready;
         @(posedge clk);
         #1;
         if (hs) idx++;
         cyc++;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      chk({tag, "_beats_accepted"}, idx, bq.size());
   endtask

   task automatic check_wire(input string tag, input wq_t w, input wq_t e);
      int s = -1;
      for (int i = 0; i < w.size(); i++) begin
         if (w[i][9]) begin
            s = i;
            break;
         end
      end
      chk({tag, "_frame_seen"}, s >= 0, 1);
      if (s < 0) return;
      for (int i = 0; i < s; i++) chk($sformatf("%s_lead[%0d]", tag, i), w[i], 12'h000);
      chk({tag, "_length"}, (w.size() - s) >= e.size(), 1);
      for (int i = 0; i < e.size() && (s + i) < w.size(); i++)
         chk($sformatf("%s_wire[%0d]", tag, i), w[s + i], e[i]);
   endtask

   task automatic run(input string tag, input int gap_at);
      w0.delete();
      w1.delete();
      mon_on = 1'b1;
      drive(tag, gap_at);
      repeat (150) @(posedge clk);
      #1;
      mon_on = 1'b0;
      repeat (12) begin
         e0.push_back(12'h000);
         e1.push_back(12'h000);
      end
      check_wire({tag, "_pad"}, w0, e0);
      check_wire({tag, "_nopad"}, w1, e1);
      bq.delete();
      e0.delete();
      e1.delete();
      nfr = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_p_out"}, {p_uf, p_sp, p_ctl1, p_ctl2, p_txd2, p_txd1}, 12'h000);
      chk({tag, "_n_out"}, {n_uf, n_sp, n_ctl1, n_ctl2, n_txd2, n_txd1}, 12'h000);
      chk({tag, "_p_tready"}, p_tready, 1'b0);
      chk({tag, "_n_tready"}, n_tready, 1'b0);
   endtask

   initial begin
      bq8_t p;
      int   s;
      rst    = 1'b1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      tdata  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Known-answer frame "123456789"
      p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      add_frame(p, 1'b0, -1);
      run("ascii", -1);
      s = -1;
      for (int i = 0; i < w1.size(); i++) begin
         if (w1[i][9]) begin
            s = i;
            break;
         end
      end
      if (s >= 0 && (s + 21) <= w1.size())
         chk("ascii_fcs", {w1[s+20][7:0], w1[s+19][7:0], w1[s+18][7:0], w1[s+17][7:0]}, 32'hCBF43926);
      else
         chk("ascii_fcs_present", 0, 1);

      // Single byte, padded to minimum
      p = {8'hAA};
      add_frame(p, 1'b0, -1);
      run("one_byte", -1);

      // Underrun after 10 bytes of a 100-byte frame
      add_frame(rand_payload(100), 1'b0, 10);
      run("underrun", 10);

      // Abort on byte 70 followed by a back-to-back frame
      add_frame(rand_payload(70), 1'b1, -1);
      add_frame(rand_payload(60), 1'b0, -1);
      run("abort", -1);

      // Two back-to-back minimum frames with tvalid held
      add_frame(rand_payload(60), 1'b0, -1);
      add_frame(rand_payload(60), 1'b0, -1);
      run("b2b", -1);

      // Random single frames, short and long
      for (int k = 0; k < 3; k++) begin
         add_frame(rand_payload($urandom_range(1, 80)), 1'b0, -1);
         run($sformatf("rand_single%0d", k), -1);
      end

      // Random back-to-back burst
      for (int k = 0; k < 3; k++) add_frame(rand_payload($urandom_range(60, 100)), 1'b0, -1);
      run("rand_b2b", -1);

      // Reset during FCS of frame 1, then a clean frame 2
      add_frame(rand_payload(60), 1'b0, -1);
      drive("rst_f1", -1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("rst_fcs");
      rst = 1'b0;
      bq.delete();
      e0.delete();
      e1.delete();
      nfr = 0;
      repeat (2) @(posedge clk);
      #1;
      add_frame(rand_payload(30), 1'b0, -1);
      run("after_rst", -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
